// File: rtl/dm_sb_pkg.sv
// Shared types and defaults for the data-memory store buffer.
package dm_sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  // Ring pointer at the default depth.
  typedef logic [SB_PTR_W-1:0] sb_ptr_t;

  // One buffered store. pc only travels to dm for trace.
  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [31:0]          pc;
  } sb_entry_t;

endpackage

// File: rtl/dm_sb_fwd_match.sv
// Store-to-load forwarding lookup: youngest valid entry whose word address
// matches ld_addr wins. Purely combinational.
module dm_sb_fwd_match
  import dm_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  sb_entry_t [DEPTH-1:0]         ent,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [ADDR_W-1:0]             ld_addr,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest (head) to youngest; a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (ent[idx].valid && (ent[idx].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        hit  = 1'b1;
        data = ent[idx].data;
      end
    end
  end

  // Byte offset and trace pc play no part in the match.
  logic [DEPTH-1:0] unused_fields;
  logic             unused_ld_lsb;
  for (genvar g = 0; g < DEPTH; g++) begin : g_unused
    assign unused_fields[g] = ^{ent[g].pc, ent[g].addr[1:0]};
  end
  assign unused_ld_lsb = ^ld_addr[1:0];

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write FIFO between the MEM-stage store path and data memory.
// Drains one store per cycle to dm, forwards buffered data to same-word loads.
// Optional: DM_SB_STORE_MERGE_EN folds a store into the youngest entry when
// it targets the same word.
module dm_store_buffer
  import dm_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [31:0]                st_pc,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       dm_we,
  output logic [ADDR_W-1:0]          dm_addr,
  output logic [DATA_W-1:0]          dm_wdata,
  output logic [31:0]                dm_pc,
  input  logic                       dm_ready,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic full;
  logic drain;
  logic alloc;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign dm_we = (count_q != '0);
  assign drain = dm_we && dm_ready;

`ifdef DM_SB_STORE_MERGE_EN
  logic [PTR_W-1:0] tail_m1;
  logic             merge_ok;
  logic             merge;

  // Youngest entry is mergeable unless it is the lone entry leaving this cycle.
  assign tail_m1  = tail_q - PTR_W'(1);
  assign merge_ok = (count_q != '0)
                 && (ent_q[tail_m1].addr[ADDR_W-1:2] == st_addr[ADDR_W-1:2])
                 && !((count_q == CNT_W'(1)) && drain);
  assign st_ready = !full || merge_ok;
  assign merge    = st_valid && merge_ok;
  assign alloc    = st_valid && !full && !merge_ok;
`else
  // A full buffer stalls the store even if the head drains this cycle.
  assign st_ready = !full;
  assign alloc    = st_valid && !full;
`endif

  // Next-state for ring contents, pointers and occupancy.
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end
    if (alloc) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].addr  = st_addr;
      ent_d[tail_q].data  = st_data;
      ent_d[tail_q].pc    = st_pc;
      tail_d              = tail_q + PTR_W'(1);
    end
`ifdef DM_SB_STORE_MERGE_EN
    if (merge) begin
      ent_d[tail_m1].data = st_data;
      ent_d[tail_m1].pc   = st_pc;
    end
`endif
    count_d = count_q + CNT_W'(alloc) - CNT_W'(drain);
  end

  // State registers; async reset drops every pending store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Drain port straight from the head register, zeroed while empty.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_pc    = '0;
    if (dm_we) begin
      dm_addr  = ent_q[head_q].addr;
      dm_wdata = ent_q[head_q].data;
      dm_pc    = ent_q[head_q].pc;
    end
  end

  assign sb_empty = (count_q == '0);
  assign sb_count = count_q;

  dm_sb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .ent     (ent_q),
    .head    (head_q),
    .ld_addr (ld_addr),
    .hit     (ld_hit),
    .data    (ld_data)
  );

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer; expectations adapt to DM_SB_STORE_MERGE_EN.
module tb_dm_store_buffer;

`ifdef DM_SB_STORE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic        clk, rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data, st_pc;
  logic [31:0] ld_addr, ld_data;
  logic        ld_hit;
  logic        dm_we, dm_ready, sb_empty;
  logic [31:0] dm_addr, dm_wdata, dm_pc;
  logic [2:0]  sb_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  dm_store_buffer dut (
    .clk(clk), .reset(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .dm_ready(dm_ready), .sb_empty(sb_empty), .sb_count(sb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every write dm actually accepts.
  always @(posedge clk) begin
    if (rst_n && dm_we && dm_ready) begin
      wa.push_back(dm_addr);
      wd.push_back(dm_wdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_pc    = a + 32'h1000;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_all(output bit ok);
    dm_ready = 1'b1;
    for (int i = 0; i < 16 && !sb_empty; i++) tick();
    ok = sb_empty;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_addr = '0; dm_ready = 1'b0;
    #12;
    n_chk++; if (dm_we !== 1'b0) $display("FAIL rst_dm_we got %b want 0", dm_we); else n_pass++;
    n_chk++; if (st_ready !== 1'b1) $display("FAIL rst_st_ready got %b want 1", st_ready); else n_pass++;
    n_chk++; if (ld_hit !== 1'b0) $display("FAIL rst_ld_hit got %b want 0", ld_hit); else n_pass++;
    n_chk++; if (sb_empty !== 1'b1) $display("FAIL rst_empty got %b want 1", sb_empty); else n_pass++;
    n_chk++; if (sb_count !== 3'd0) $display("FAIL rst_count got %0d want 0", sb_count); else n_pass++;
    n_chk++; if (dm_addr !== 32'h0) $display("FAIL rst_dm_addr got %h want 0", dm_addr); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    bit ok;
    wa.delete(); wd.delete();
    dm_ready = 1'b1;
    store(32'h10, 32'h1111_1111);
    n_chk++; if (dm_we !== 1'b1) $display("FAIL single_we got %b want 1", dm_we); else n_pass++;
    n_chk++; if (dm_addr !== 32'h10) $display("FAIL single_addr got %h want 10", dm_addr); else n_pass++;
    n_chk++; if (dm_wdata !== 32'h1111_1111) $display("FAIL single_data got %h want 11111111", dm_wdata); else n_pass++;
    n_chk++; if (dm_pc !== 32'h1010) $display("FAIL single_pc got %h want 1010", dm_pc); else n_pass++;
    tick();
    n_chk++; if (sb_empty !== 1'b1) $display("FAIL single_empty got %b want 1", sb_empty); else n_pass++;
    n_chk++; if (wa.size() != 1) $display("FAIL single_nwr got %0d want 1", wa.size()); else n_pass++;
    drain_all(ok);
  endtask

  task automatic test_full_order;
    bit ok;
    logic [31:0] g;
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hA0 + 32'(i));
    n_chk++; if (sb_count !== 3'd4) $display("FAIL full_count got %0d want 4", sb_count); else n_pass++;
    n_chk++; if (st_ready !== 1'b0) $display("FAIL full_st_ready got %b want 0", st_ready); else n_pass++;
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEAD; st_pc = 32'h0;
    tick();
    st_valid = 1'b0;
    n_chk++; if (sb_count !== 3'd4) $display("FAIL full_held got %0d want 4", sb_count); else n_pass++;
    wa.delete(); wd.delete();
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (dm_addr !== 32'(4 * i)) $display("FAIL order_addr%0d got %h want %h", i, dm_addr, 4 * i); else n_pass++;
      n_chk++; if (dm_wdata !== 32'hA0 + 32'(i)) $display("FAIL order_data%0d got %h want %h", i, dm_wdata, 32'hA0 + i); else n_pass++;
      tick();
    end
    n_chk++; if (sb_empty !== 1'b1) $display("FAIL order_empty got %b want 1", sb_empty); else n_pass++;
    g = (wa.size() > 3) ? wa[3] : 32'hx;
    n_chk++; if (wa.size() != 4 || g !== 32'hC) $display("FAIL order_log got n=%0d last=%h want n=4 last=c", wa.size(), g); else n_pass++;
    drain_all(ok);
  endtask

  task automatic test_forward;
    bit ok;
    int drains;
    logic [31:0] f;
    wa.delete(); wd.delete();
    dm_ready = 1'b0;
    store(32'h20, 32'hA);
    store(32'h20, 32'hB);
    n_chk++; if (sb_count !== (MERGE ? 3'd1 : 3'd2)) $display("FAIL fwd_count got %0d want %0d", sb_count, MERGE ? 1 : 2); else n_pass++;
    ld_addr = 32'h22; #1;
    n_chk++; if (ld_hit !== 1'b1) $display("FAIL fwd_hit got %b want 1", ld_hit); else n_pass++;
    n_chk++; if (ld_data !== 32'hB) $display("FAIL fwd_youngest got %h want b", ld_data); else n_pass++;
    ld_addr = 32'h24; #1;
    n_chk++; if (ld_hit !== 1'b0) $display("FAIL fwd_miss got %b want 0", ld_hit); else n_pass++;
    n_chk++; if (ld_data !== 32'h0) $display("FAIL fwd_miss_data got %h want 0", ld_data); else n_pass++;
    // The entry leaving this cycle must still forward.
    ld_addr = 32'h20; dm_ready = 1'b1;
    drains = 0;
    while (!sb_empty && drains < 8) begin
      #1;
      n_chk++; if (ld_hit !== 1'b1 || ld_data !== 32'hB) $display("FAIL fwd_drain%0d got %b/%h want 1/b", drains, ld_hit, ld_data); else n_pass++;
      tick();
      drains++;
    end
    n_chk++; if (ld_hit !== 1'b0) $display("FAIL fwd_after got %b want 0", ld_hit); else n_pass++;
    f = (wd.size() > 0) ? wd[0] : 32'hx;
    n_chk++; if (wd.size() != (MERGE ? 1 : 2) || f !== (MERGE ? 32'hB : 32'hA))
      $display("FAIL fwd_log got n=%0d first=%h want n=%0d first=%h", wd.size(), f, MERGE ? 1 : 2, MERGE ? 32'hB : 32'hA);
    else n_pass++;
    ld_addr = '0;
    drain_all(ok);
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [31:0] g;
    wa.delete(); wd.delete();
    dm_ready = 1'b0;
    store(32'h50, 32'h50);
    store(32'h54, 32'h54);
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 32'h58 + 32'(4 * i); st_data = st_addr; st_pc = '0;
      tick();
      n_chk++; if (sb_count !== 3'd2) $display("FAIL b2b_count%0d got %0d want 2", i, sb_count); else n_pass++;
    end
    st_valid = 1'b0;
    drain_all(ok);
    n_chk++; if (!ok) $display("FAIL b2b_drain got busy want empty"); else n_pass++;
    n_chk++; if (wa.size() != 6) $display("FAIL b2b_nwr got %0d want 6", wa.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      g = (wa.size() > i) ? wa[i] : 32'hx;
      n_chk++; if (g !== 32'h50 + 32'(4 * i)) $display("FAIL b2b_order%0d got %h want %h", i, g, 32'h50 + 4 * i); else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    dm_ready = 1'b0;
    store(32'h90, 32'h1);
    store(32'h94, 32'h2);
    store(32'h98, 32'h3);
    n_chk++; if (sb_count !== 3'd3) $display("FAIL arst_pre got %0d want 3", sb_count); else n_pass++;
    #2;
    rst_n = 1'b0;
    wa.delete(); wd.delete();
    #1;
    n_chk++; if (dm_we !== 1'b0) $display("FAIL arst_we got %b want 0", dm_we); else n_pass++;
    n_chk++; if (sb_count !== 3'd0) $display("FAIL arst_count got %0d want 0", sb_count); else n_pass++;
    n_chk++; if (st_ready !== 1'b1) $display("FAIL arst_st_ready got %b want 1", st_ready); else n_pass++;
    n_chk++; if (dm_wdata !== 32'h0) $display("FAIL arst_wdata got %h want 0", dm_wdata); else n_pass++;
    dm_ready = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++; if (wa.size() != 0) $display("FAIL arst_nwr got %0d want 0", wa.size()); else n_pass++;
    n_chk++; if (dm_we !== 1'b0) $display("FAIL arst_after_we got %b want 0", dm_we); else n_pass++;
  endtask

  task automatic test_merge;
    bit ok;
    logic [31:0] g;
    wa.delete(); wd.delete();
    dm_ready = 1'b0;
    store(32'h40, 32'h1);
    store(32'h40, 32'h2);
    n_chk++; if (sb_count !== (MERGE ? 3'd1 : 3'd2)) $display("FAIL merge_count got %0d want %0d", sb_count, MERGE ? 1 : 2); else n_pass++;
    drain_all(ok);
    g = (wd.size() > 0) ? wd[wd.size() - 1] : 32'hx;
    n_chk++; if (wd.size() != (MERGE ? 1 : 2) || g !== 32'h2)
      $display("FAIL merge_log got n=%0d last=%h want n=%0d last=2", wd.size(), g, MERGE ? 1 : 2);
    else n_pass++;
    // Full buffer, incoming store to the youngest word.
    wa.delete(); wd.delete();
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h70 + 32'(4 * i), 32'h70 + 32'(4 * i));
    st_valid = 1'b1; st_addr = 32'h7C; st_data = 32'h99; st_pc = '0;
    #1;
    n_chk++; if (st_ready !== MERGE) $display("FAIL merge_full_ready got %b want %b", st_ready, MERGE); else n_pass++;
    tick();
    st_valid = 1'b0;
    n_chk++; if (sb_count !== 3'd4) $display("FAIL merge_full_count got %0d want 4", sb_count); else n_pass++;
    drain_all(ok);
    g = (wd.size() > 3) ? wd[3] : 32'hx;
    n_chk++; if (wd.size() != 4 || g !== (MERGE ? 32'h99 : 32'h7C))
      $display("FAIL merge_full_log got n=%0d last=%h want n=4 last=%h", wd.size(), g, MERGE ? 32'h99 : 32'h7C);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_order();
    test_forward();
    test_back_to_back();
    test_async_reset();
    test_merge();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
